// File: rtl/ripple_counter_n.sv
// ripple_counter_n: negedge JK-toggle ripple counter with async load, count enable
// and a posedge-registered copy of the count plus terminal-count flag.
module ripple_counter_n #(
    parameter int WIDTH = 4,
    parameter bit UP    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_sync,
    output logic             tc
);
    localparam logic [WIDTH-1:0] TERM = UP ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] stage_clk;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] clr;

    // Reset folds into the per-stage clear so each stage has one set and one clear pin;
    // set is gated by rst so the two never assert together.
    assign set = {WIDTH{rst & load}} & d;
    assign clr = {WIDTH{~rst}} | ({WIDTH{load}} & ~d);
    assign tog = {{(WIDTH-1){1'b1}}, en};
    assign stage_clk[0] = clk;

    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_clk
            assign stage_clk[i] = UP ? q[i-1] : ~q[i-1];
        end
        for (i = 0; i < WIDTH; i++) begin : g_stage
            logic s;
            always_ff @(negedge stage_clk[i] or posedge set[i] or posedge clr[i]) begin
                if (clr[i])
                    s <= 1'b0;
                else if (set[i])
                    s <= 1'b1;
                else if (tog[i])
                    s <= ~s;
            end
            assign q[i] = s;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_sync <= '0;
            tc     <= 1'b0;
        end else begin
            q_sync <= q;
            tc     <= (q == TERM);
        end
    end
endmodule

// File: tb/tb_ripple_counter_n.sv
// tb_ripple_counter_n: drives a 4-bit down, 4-bit up and 8-bit down instance with
// shared stimulus; expected q_sync/tc go through a queue from negedge to posedge.
module tb_ripple_counter_n;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] d = '0;
    logic [3:0] q_d4, qs_d4, q_u4, qs_u4;
    logic [7:0] q_d8, qs_d8;
    logic       tc_d4, tc_u4, tc_d8;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit         ld;
        logic [7:0] dv;
        bit         en;
        logic [3:0] e_d4;
        logic [3:0] e_u4;
        logic [7:0] e_d8;
    } vec_t;

    typedef struct {
        logic [3:0] d4;
        logic [3:0] u4;
        logic [7:0] d8;
    } exp_t;

    exp_t sb[$];
    exp_t ps;
    vec_t tbl[11];
    bit   seen[256];

    ripple_counter_n #(.WIDTH(4), .UP(1'b0)) dut_d4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d[3:0]),
        .q(q_d4), .q_sync(qs_d4), .tc(tc_d4)
    );
    ripple_counter_n #(.WIDTH(4), .UP(1'b1)) dut_u4 (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d[3:0]),
        .q(q_u4), .q_sync(qs_u4), .tc(tc_u4)
    );
    ripple_counter_n #(.WIDTH(8), .UP(1'b0)) dut_d8 (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d),
        .q(q_d8), .q_sync(qs_d8), .tc(tc_d8)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_q_d4"}, q_d4, 0);
        chk({nm, "_q_u4"}, q_u4, 0);
        chk({nm, "_q_d8"}, q_d8, 0);
        chk({nm, "_qs_d4"}, qs_d4, 0);
        chk({nm, "_qs_u4"}, qs_u4, 0);
        chk({nm, "_qs_d8"}, qs_d8, 0);
        chk({nm, "_tc_d4"}, tc_d4, 0);
        chk({nm, "_tc_u4"}, tc_u4, 0);
        chk({nm, "_tc_d8"}, tc_d8, 0);
    endtask

    // Called just after a posedge; leaves load high.
    task automatic do_load(input logic [7:0] v);
        load = 1'b1;
        d = v;
        #1;
        chk("load_q_d4", q_d4, v[3:0]);
        chk("load_q_u4", q_u4, v[3:0]);
        chk("load_q_d8", q_d8, v);
    endtask

    // Called just after a posedge: one negedge (raw q check, enqueue) and one posedge (dequeue).
    task automatic step(input bit e, input logic [3:0] d4, input logic [3:0] u4, input logic [7:0] d8);
        exp_t x;
        en = e;
        @(negedge clk);
        #1;
        chk("q_d4", q_d4, d4);
        chk("q_u4", q_u4, u4);
        chk("q_d8", q_d8, d8);
        chk("lag_d4", qs_d4, ps.d4);
        chk("lag_u4", qs_u4, ps.u4);
        chk("lag_d8", qs_d8, ps.d8);
        sb.push_back('{d4, u4, d8});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            x = sb.pop_front();
            chk("qs_d4", qs_d4, x.d4);
            chk("qs_u4", qs_u4, x.u4);
            chk("qs_d8", qs_d8, x.d8);
            chk("tc_d4", tc_d4, 32'(x.d4 == 4'h0));
            chk("tc_u4", tc_u4, 32'(x.u4 == 4'hF));
            chk("tc_d8", tc_d8, 32'(x.d8 == 8'h00));
            ps = x;
        end
    endtask

    task automatic release_reset();
        en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_qs_d4", qs_d4, 0);
        chk("rel_tc_d4", tc_d4, 1);
        chk("rel_tc_u4", tc_u4, 0);
        chk("rel_tc_d8", tc_d8, 1);
        ps = '{4'h0, 4'h0, 8'h00};
    endtask

    initial begin
        int distinct;
        tbl[0]  = '{1'b0, 8'h00, 1'b1, 4'hF, 4'h1, 8'hFF};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 4'hE, 4'h2, 8'hFE};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 4'hD, 4'h3, 8'hFD};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 4'hC, 4'h4, 8'hFC};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 4'hB, 4'h5, 8'hFB};
        tbl[5]  = '{1'b1, 8'h07, 1'b0, 4'h7, 4'h7, 8'h07};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 4'h7, 4'h7, 8'h07};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 4'h7, 4'h7, 8'h07};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 4'h6, 4'h8, 8'h06};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 4'h5, 4'h9, 8'h05};
        tbl[10] = '{1'b1, 8'h0A, 1'b1, 4'h9, 4'hB, 8'h09};
        ps = '{4'h0, 4'h0, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        load = 1'b1;
        d = 8'hFF;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("rst_load");
        load = 1'b0;
        release_reset();

        for (int k = 0; k < 11; k++) begin
            if (tbl[k].ld) begin
                do_load(tbl[k].dv);
                load = 1'b0;
            end
            step(tbl[k].en, tbl[k].e_d4, tbl[k].e_u4, tbl[k].e_d8);
        end

        // Load held while d changes, q_sync follows at the next posedge, then count from A.
        do_load(8'h09);
        #1;
        d = 8'h0A;
        #1;
        chk("reload_q_d4", q_d4, 4'hA);
        chk("reload_q_d8", q_d8, 8'h0A);
        @(posedge clk);
        #1;
        chk("load_qs_d4", qs_d4, 4'hA);
        chk("load_qs_u4", qs_u4, 4'hA);
        chk("load_qs_d8", qs_d8, 8'h0A);
        ps = '{4'hA, 4'hA, 8'h0A};
        load = 1'b0;
        step(1'b1, 4'h9, 4'hB, 8'h09);
        step(1'b1, 4'h8, 4'hC, 8'h08);
        step(1'b1, 4'h7, 4'hD, 8'h07);
        step(1'b1, 4'h6, 4'hE, 8'h06);
        step(1'b1, 4'h5, 4'hF, 8'h05);

        // Mid-cycle reset with q=5 (down) and tc=1 (up); load during reset is ignored.
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        load = 1'b1;
        d = 8'hFF;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk_all_zero("midrst_load");
        load = 1'b0;
        release_reset();

        for (int k = 1; k <= 256; k++) begin
            step(1'b1, 4'(256 - k), 4'(k), 8'(256 - k));
            if (seen[qs_d8])
                chk("sweep_repeat", qs_d8, 32'hFFFF_FFFF);
            seen[qs_d8] = 1'b1;
        end
        distinct = 0;
        for (int v = 0; v < 256; v++)
            if (seen[v])
                distinct++;
        chk("sweep_distinct", distinct, 256);
        chk("sweep_end_tc", tc_d8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
